// File: rtl/assert_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assert_pkg : shared FSM encoding and width helper for the arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package assert_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int f_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/assert_event_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin select, first request at or      |
// | above i_ptr (wrapping).                                  Rev 1.0     |
// +----------------------------------------------------------------------+
module rr_pick
   import assert_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = f_clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [SRC_W-1:0]   i_ptr,
   output logic [SRC_W-1:0]   o_grant,
   output logic               o_any
);

   logic [SRC_W-1:0] w_grant;
   logic             w_any;
   logic [SRC_W:0]   w_sum;
   logic [SRC_W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (SRC_W + 1)'(k);
         if (w_sum >= (SRC_W + 1)'(NUM_SRC))
            w_sum = w_sum - (SRC_W + 1)'(NUM_SRC);
         w_idx = w_sum[SRC_W-1:0];
         if (i_req[w_idx]) begin
            w_grant = w_idx;
            w_any   = 1'b1;
         end
      end
   end

   assign o_grant = w_grant;
   assign o_any   = w_any;

endmodule
`default_nettype wire

// File: rtl/assert_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assert_event_arbiter : time-stamps checker failures, serialises them |
// | round-robin onto a valid/ready channel, counts, raises halt.  Rev 1.0|
// +----------------------------------------------------------------------+
module assert_event_arbiter
   import assert_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int CYCLE_W = 16,
   parameter int CNT_W   = 8,
   localparam int SRC_W  = f_clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_enable,
   input  logic               i_clear,
   input  logic [NUM_SRC-1:0] i_fail_in,
   input  logic [CNT_W-1:0]   i_fail_max,
   output logic               o_rpt_valid,
   input  logic               i_rpt_ready,
   output logic [SRC_W-1:0]   o_rpt_src,
   output logic [CYCLE_W-1:0] o_rpt_cycle,
   output logic [NUM_SRC-1:0] o_pending,
   output logic [CNT_W-1:0]   o_fail_count,
   output logic               o_overrun,
   output logic               o_halt_req
);

   localparam int SUM_W = CNT_W + SRC_W + 1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [CYCLE_W-1:0] r_cycle_cnt;
   logic [NUM_SRC-1:0] r_pending;
   logic [CYCLE_W-1:0] r_stamp [NUM_SRC];
   logic [SRC_W-1:0]   r_rr_ptr;
   logic [SRC_W-1:0]   r_rpt_src;
   logic [CYCLE_W-1:0] r_rpt_cycle;
   logic [CNT_W-1:0]   r_fail_count;
   logic               r_overrun;
   logic               r_halt_req;

   logic [NUM_SRC-1:0] w_event;
   logic [NUM_SRC-1:0] w_drain;
   logic [SRC_W:0]     w_popcnt;
   logic [SUM_W-1:0]   w_sum;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_ovr_hit;
   logic [SRC_W-1:0]   w_grant;
   logic               w_any;
   logic               w_rpt_valid;
   logic               w_load;
   logic               w_accept;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_rr_pick (
      .i_req   (r_pending),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_clear) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_any)       w_state_nxt = ST_SEND;
            ST_SEND: if (i_rpt_ready) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rpt_valid = (r_state == ST_SEND);
      w_load      = (r_state == ST_IDLE) && w_any && !i_clear;
      w_accept    = w_rpt_valid && i_rpt_ready && !i_clear;
   end

   // ---------------- Event qualification and counting ----------------
   always_comb begin
      w_event  = (i_enable && !i_clear) ? i_fail_in : '0;
      w_drain  = '0;
      w_popcnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_drain[i] = w_accept && (r_rpt_src == SRC_W'(i));
         w_popcnt   = w_popcnt + {{SRC_W{1'b0}}, w_event[i]};
      end
      w_ovr_hit = |(w_event & r_pending & ~w_drain);
      w_sum     = {{(SRC_W + 1){1'b0}}, r_fail_count} + {{CNT_W{1'b0}}, w_popcnt};
      w_cnt_nxt = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt  <= '0;
         r_fail_count <= '0;
         r_overrun    <= 1'b0;
         r_halt_req   <= 1'b0;
      end else if (i_clear) begin
         r_cycle_cnt  <= '0;
         r_fail_count <= '0;
         r_overrun    <= 1'b0;
         r_halt_req   <= 1'b0;
      end else begin
         if (i_enable) r_cycle_cnt <= r_cycle_cnt + 1'b1;
         r_fail_count <= w_cnt_nxt;
         if (w_ovr_hit) r_overrun <= 1'b1;
         if ((i_fail_max != '0) && (w_cnt_nxt >= i_fail_max)) r_halt_req <= 1'b1;
      end
   end

   // A source drained in the same cycle it fails again re-latches with a fresh stamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         for (int i = 0; i < NUM_SRC; i++) r_stamp[i] <= '0;
      end else if (i_clear) begin
         r_pending <= '0;
         for (int i = 0; i < NUM_SRC; i++) r_stamp[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_event[i] && (!r_pending[i] || w_drain[i])) begin
               r_pending[i] <= 1'b1;
               r_stamp[i]   <= r_cycle_cnt;
            end else if (w_drain[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   // ---------------- Report holding registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rpt_src   <= '0;
         r_rpt_cycle <= '0;
         r_rr_ptr    <= '0;
      end else if (i_clear) begin
         r_rpt_src   <= '0;
         r_rpt_cycle <= '0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_load) begin
            r_rpt_src   <= w_grant;
            r_rpt_cycle <= r_stamp[w_grant];
         end
         if (w_accept) begin
            if (r_rpt_src == SRC_W'(NUM_SRC - 1)) r_rr_ptr <= '0;
            else                                  r_rr_ptr <= r_rpt_src + 1'b1;
         end
      end
   end

   assign o_rpt_valid  = w_rpt_valid;
   assign o_rpt_src    = r_rpt_src;
   assign o_rpt_cycle  = r_rpt_cycle;
   assign o_pending    = r_pending;
   assign o_fail_count = r_fail_count;
   assign o_overrun    = r_overrun;
   assign o_halt_req   = r_halt_req;

endmodule
`default_nettype wire

// File: tb/tb_assert_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_assert_event_arbiter : directed bench with report scoreboard      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_assert_event_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       clear;
   logic [3:0] fail_in;
   logic [7:0] fail_max;
   logic       rpt_valid;
   logic       rpt_ready;
   logic [1:0] rpt_src;
   logic [3:0] rpt_cycle;
   logic [3:0] pending;
   logic [7:0] fail_count;
   logic       overrun;
   logic       halt_req;

   int         vectors    = 0;
   int         miscompares = 0;
   int         tb_cnt     = 0;
   logic [5:0] sb [$];
   logic [5:0] exp_rpt;

   assert_event_arbiter #(
      .NUM_SRC (4),
      .CYCLE_W (4),
      .CNT_W   (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_enable     (enable),
      .i_clear      (clear),
      .i_fail_in    (fail_in),
      .i_fail_max   (fail_max),
      .o_rpt_valid  (rpt_valid),
      .i_rpt_ready  (rpt_ready),
      .o_rpt_src    (rpt_src),
      .o_rpt_cycle  (rpt_cycle),
      .o_pending    (pending),
      .o_fail_count (fail_count),
      .o_overrun    (overrun),
      .o_halt_req   (halt_req)
   );

   always #5 clk = ~clk;

   // Monitor: a handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && !clear && rpt_valid && rpt_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL report: unexpected src=%0d cycle=%0d, none expected", rpt_src, rpt_cycle);
         end else begin
            exp_rpt = sb.pop_front();
            if ({rpt_src, rpt_cycle} != exp_rpt) begin
               miscompares++;
               $display("FAIL report: got src=%0d cycle=%0d, expected src=%0d cycle=%0d",
                        rpt_src, rpt_cycle, exp_rpt[5:4], exp_rpt[3:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n && clear)       tb_cnt = 0;
      else if (rst_n && enable) tb_cnt = (tb_cnt + 1) % 16;
      #1;
   endtask

   task automatic push_exp(input int s, input int c);
      sb.push_back({2'(s), 4'(c)});
   endtask

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; clear = 1'b0; fail_in = '0;
      fail_max = '0; rpt_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      // Reset state
      chk("rst_valid", rpt_valid, 0);
      chk("rst_pending", pending, 0);
      chk("rst_count", fail_count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_halt", halt_req, 0);
      chk("rst_src", rpt_src, 0);
      chk("rst_cycle", rpt_cycle, 0);

      // 1: single failure stamped at cycle 5
      enable = 1'b1;
      repeat (5) tick();
      fail_in = 4'b0001; push_exp(0, 5);
      tick();
      fail_in = '0;
      chk("t1_pending", pending, 1);
      chk("t1_count", fail_count, 1);
      tick();
      chk("t1_valid", rpt_valid, 1);
      chk("t1_src", rpt_src, 0);
      chk("t1_cycle", rpt_cycle, 5);
      rpt_ready = 1'b1;
      repeat (2) tick();
      chk("t1_pending_done", pending, 0);
      chk("t1_valid_done", rpt_valid, 0);

      // 2: round robin, then continuation from rr pointer
      do_clear();
      chk("t2_count_clr", fail_count, 0);
      repeat (2) tick();
      fail_in = 4'b1111;
      for (int s = 0; s < 4; s++) push_exp(s, tb_cnt);
      tick();
      fail_in = '0;
      chk("t2_count", fail_count, 4);
      chk("t2_pending", pending, 15);
      repeat (9) tick();
      chk("t2_drained", pending, 0);
      fail_in = 4'b0010; push_exp(1, tb_cnt);
      tick();
      fail_in = '0;
      repeat (3) tick();
      fail_in = 4'b1111;
      push_exp(2, tb_cnt); push_exp(3, tb_cnt); push_exp(0, tb_cnt); push_exp(1, tb_cnt);
      tick();
      fail_in = '0;
      repeat (9) tick();
      chk("t2_count_total", fail_count, 9);
      chk("t2_overrun", overrun, 0);

      // 3: overrun under backpressure
      do_clear();
      rpt_ready = 1'b0;
      repeat (3) tick();
      fail_in = 4'b0100; push_exp(2, 3);
      tick();
      fail_in = '0;
      repeat (3) tick();
      fail_in = 4'b0100;
      tick();
      fail_in = '0;
      chk("t3_overrun", overrun, 1);
      chk("t3_count", fail_count, 2);
      chk("t3_valid", rpt_valid, 1);
      chk("t3_src", rpt_src, 2);
      chk("t3_cycle", rpt_cycle, 3);
      rpt_ready = 1'b1;
      repeat (3) tick();
      chk("t3_pending_done", pending, 0);
      chk("t3_overrun_sticky", overrun, 1);

      // 3b: failure on the handoff cycle re-latches without overrun
      do_clear();
      rpt_ready = 1'b0;
      fail_in = 4'b0001; push_exp(0, tb_cnt);
      tick();
      fail_in = '0;
      tick();
      rpt_ready = 1'b1;
      fail_in = 4'b0001; push_exp(0, tb_cnt);
      tick();
      fail_in = '0;
      chk("t3b_overrun", overrun, 0);
      chk("t3b_pending", pending, 1);
      repeat (3) tick();
      chk("t3b_pending_done", pending, 0);

      // 4: halt threshold
      do_clear();
      fail_max = 8'd3;
      for (int k = 0; k < 3; k++) begin
         fail_in = 4'b0010; push_exp(1, tb_cnt);
         tick();
         fail_in = '0;
         chk("t4_halt", halt_req, (k == 2) ? 1 : 0);
         repeat (3) tick();
      end
      chk("t4_halt_sticky", halt_req, 1);
      chk("t4_count", fail_count, 3);
      do_clear();
      chk("t4_halt_clr", halt_req, 0);
      fail_max = 8'd0;
      fail_in = 4'b1111;
      for (int s = 0; s < 4; s++) push_exp(s, tb_cnt);
      tick();
      fail_in = '0;
      repeat (9) tick();
      chk("t4_no_halt", halt_req, 0);
      chk("t4_count4", fail_count, 4);
      fail_max = 8'd2;
      tick();
      chk("t4_lower_max", halt_req, 1);

      // 5: clear during SEND drops the report
      fail_max = 8'd0;
      do_clear();
      rpt_ready = 1'b0;
      fail_in = 4'b0001;
      tick();
      fail_in = '0;
      tick();
      chk("t5_valid", rpt_valid, 1);
      rpt_ready = 1'b1; clear = 1'b1; fail_in = 4'b0010;
      tick();
      clear = 1'b0; fail_in = '0;
      chk("t5_valid_clr", rpt_valid, 0);
      chk("t5_pending_clr", pending, 0);
      chk("t5_count_clr", fail_count, 0);
      chk("t5_halt_clr", halt_req, 0);
      repeat (3) tick();
      chk("t5_no_report", rpt_valid, 0);

      // 6: async reset during SEND, then stamp wrap 15 -> 0
      rpt_ready = 1'b0;
      fail_in = 4'b0100;
      tick();
      fail_in = '0;
      tick();
      chk("t6_valid", rpt_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid_rst", rpt_valid, 0);
      chk("t6_pending_rst", pending, 0);
      chk("t6_count_rst", fail_count, 0);
      tb_cnt = 0;
      tick();
      rst_n = 1'b1;
      rpt_ready = 1'b1;
      repeat (15) tick();
      fail_in = 4'b0001; push_exp(0, 15);
      tick();
      fail_in = 4'b0010; push_exp(1, 0);
      tick();
      fail_in = '0;
      repeat (6) tick();
      chk("t6_count", fail_count, 2);
      enable = 1'b0;
      fail_in = 4'b1000;
      tick();
      fail_in = '0;
      chk("t6_disabled_pending", pending, 0);
      chk("t6_disabled_count", fail_count, 2);
      repeat (2) tick();

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
